// File: rtl/nios2_oci_dct_packer.sv
// DCT atom packer: 2-bit atoms into 30-bit frames; a frame is visible the cycle after its filling atom or flush.
// A blocked emit holds the accumulator (atom_ready drops when full); NIOS_OCI_DCT_TIMEOUT_EN adds an idle-timeout flush.
module nios2_oci_dct_packer #(
  parameter int MAX_ATOMS     = 15,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_on,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_partial,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ATOMS);

  if (MAX_ATOMS < 1 || MAX_ATOMS > 15 || FLUSH_TIMEOUT < 2 || FLUSH_TIMEOUT > 255) begin : g_bad_param
    $error("nios2_oci_dct_packer: parameter out of range");
  end

  state_t      state;
  logic [29:0] acc;
  logic [3:0]  acc_cnt;
  logic        flush_pend;

  logic        accept;
  logic        drop;
  logic [29:0] post_acc;
  logic [3:0]  post_cnt;
  logic        emit_req;
  logic        emit;
  logic        timeout;

  assign atom_ready = (state == ACCUM) && (acc_cnt < MAX_CNT);

  // Emit decisions look at post-accept contents so a same-cycle atom rides along in the frame.
  always_comb begin
    accept   = 1'b0;
    drop     = 1'b0;
    post_acc = acc;
    post_cnt = acc_cnt;
    emit_req = 1'b0;
    emit     = 1'b0;
    accept   = atom_valid && (atom != 2'b00) && atom_ready;
    drop     = atom_valid && (atom != 2'b00) && (state == ACCUM) && (acc_cnt == MAX_CNT);
    if (accept) begin
      post_acc = {acc[27:0], atom};
      post_cnt = acc_cnt + 4'd1;
    end
    emit_req = (state != IDLE) &&
               ((post_cnt == MAX_CNT) ||
                ((flush || flush_pend) && (post_cnt != 4'd0)) ||
                ((state == DRAIN) && (acc_cnt != 4'd0)) ||
                timeout);
    emit     = emit_req && (!frame_valid || frame_ready);
  end

`ifdef NIOS_OCI_DCT_TIMEOUT_EN
  logic [7:0] idle_cnt;

  assign timeout = (state == ACCUM) && (acc_cnt != 4'd0) && (idle_cnt >= 8'(FLUSH_TIMEOUT));

  // Saturates at the threshold so a blocked timeout emit stays requested.
  always_ff @(posedge clk) begin
    if (!reset_n || (state != ACCUM) || accept || emit) begin
      idle_cnt <= 8'd0;
    end else if ((acc_cnt != 4'd0) && (idle_cnt < 8'(FLUSH_TIMEOUT))) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      acc           <= 30'd0;
      acc_cnt       <= 4'd0;
      flush_pend    <= 1'b0;
      frame_valid   <= 1'b0;
      dct_buffer    <= 30'd0;
      dct_count     <= 4'd0;
      frame_partial <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (emit) begin
        dct_buffer    <= post_acc;
        dct_count     <= post_cnt;
        frame_partial <= (post_cnt < MAX_CNT);
        frame_valid   <= 1'b1;
        acc           <= 30'd0;
        acc_cnt       <= 4'd0;
        flush_pend    <= 1'b0;
      end else begin
        if (frame_valid && frame_ready) begin
          frame_valid <= 1'b0;
        end
        acc     <= post_acc;
        acc_cnt <= post_cnt;
        if (flush && (post_cnt != 4'd0)) begin
          flush_pend <= 1'b1;
        end
      end
      case (state)
        IDLE:    if (trc_on) state <= ACCUM;
        ACCUM:   if (!trc_on) state <= DRAIN;
        DRAIN:   if ((acc_cnt == 4'd0) || emit) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
- Upstream feeder of the OCI trace test bench and trace FIFO. Packs 2-bit direct-control-transfer (DCT) atoms from the CPU trace path into 30-bit frames and presents them as dct_buffer/dct_count.
- Emits a frame when the buffer fills, on explicit flush, when trace is switched off, or on idle timeout (optional).
- One-deep output register with a valid/ready handshake toward the trace FIFO.

Parameters:
- MAX_ATOMS, 15, atoms per full frame; legal range 1..15; frame width fixed at 30 bits.
- FLUSH_TIMEOUT, 64, idle cycles before a partial frame is forced out; used only with the optional feature; range 2..255.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- trc_on  in  1  trace enable.
- atom_valid  in  1  atom present this cycle.
- atom  in  2  01 not-taken, 10 taken, 11 exception marker; 00 ignored (not accepted, not counted).
- atom_ready  out  1  packer can accept an atom.
- flush  in  1  force out the current partial frame.
- frame_ready  in  1  downstream accepts the frame.
- frame_valid  out  1  dct_buffer/dct_count valid.
- dct_buffer  out  30  packed atoms, right-justified, newest in [1:0], unused upper bits zero.
- dct_count  out  4  number of atoms in the frame, 1..MAX_ATOMS.
- frame_partial  out  1  frame is shorter than MAX_ATOMS.
- overflow  out  1  sticky: an atom was dropped.

Behaviour:
- Reset (reset_n=0 at edge): state IDLE. Accumulator and all outputs cleared: atom_ready=0, frame_valid=0, dct_buffer=0, dct_count=0, frame_partial=0, overflow=0. Held frames and partial frames are discarded, with no handshake completion.
- States:
  - IDLE: atom_ready=0, atoms ignored and not counted as overflow. trc_on=1 -> ACCUM.
  - ACCUM: atoms accepted.
    - trc_on=0 -> DRAIN.
  - DRAIN: atoms ignored. If the accumulator count is greater than 0, emit a partial frame when the output register is free, then go to IDLE. If the count is 0, go to IDLE next cycle.
- Accept: atom_valid & atom!=00 & atom_ready. On accept, acc <= {acc[27:0], atom} and acc_cnt+1.
- atom_ready = (state==ACCUM) & (acc_cnt < MAX_ATOMS).
- Drop: atom_valid & atom!=00 in ACCUM with acc_cnt==MAX_ATOMS sets overflow. overflow clears only on reset.
- Emit conditions, evaluated on post-accept contents so the atom accepted this cycle is included:
  - count reaches MAX_ATOMS;
  - flush with count>0;
  - DRAIN with count>0;
  - timeout.
- Emit proceeds when frame_valid=0 or frame_ready=1.
  - On the next edge: output register loads acc/count, frame_valid=1, frame_partial=(count<MAX_ATOMS).
  - The accumulator clears to 0. A same-cycle accept is folded into the emitted frame, never into the cleared accumulator.
- A blocked emit stays pending. The accumulator holds, and a full accumulator deasserts atom_ready.
- flush while blocked: the flush request is latched until the emit occurs. flush with count 0 does nothing.
- Handshake: a frame completes when frame_valid & frame_ready at an edge. frame_valid falls unless a new emit loads the same edge, giving back-to-back frames with no bubble. dct_buffer/dct_count are stable while frame_valid=1 & frame_ready=0.
- Latency: the frame is visible the cycle after the filling atom or flush.

Optional Feature:
- Macro: NIOS_OCI_DCT_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter increments each ACCUM cycle with count>0 and no accept.
  - The counter resets on accept or emit.
  - Reaching FLUSH_TIMEOUT raises an emit condition, producing a partial frame.
- Undefined: the counter and logic are absent, and partial frames leave only via flush or trc_on falling.

Test Plan:
- trc_on=1, frame_ready=1, 15 atoms of 10 on consecutive cycles -> the next cycle shows frame_valid=1, dct_buffer=30'h2AAAAAAA, dct_count=15, frame_partial=0, for one cycle.
- Atoms 01,10,11 then flush -> dct_buffer=30'h0000001B, dct_count=3, frame_partial=1; the accumulator is empty afterwards.
- frame_ready=0, 30 atoms of 01 -> the first frame is held stable with dct_count=15, atom_ready=0 after the 30th atom, a 31st atom sets overflow=1.
  - Then raise frame_ready -> the two frames complete on consecutive cycles, both 30'h15555555.
- 5 atoms then trc_on=0 -> a partial frame with dct_count=5 is emitted and the state returns to IDLE. Subsequent atoms are ignored, overflow stays 0.
- Macro defined, FLUSH_TIMEOUT=8: 2 atoms (10,01) then 8 idle cycles -> a frame with dct_buffer=30'h9, dct_count=2. Macro undefined -> no frame is emitted.
- reset_n=0 for one edge mid-accumulation with frame_valid=1 held -> all outputs are 0 and the state is IDLE the following cycle. The held frame is never completed.
